display_scan_ctrl: RTL and testbench

Time-multiplexes one shared BCD-to-7-segment decoder across four digits (S_ONES, S_TENS, M_ONES, M_TENS of the clock counter).
- Sequences fixed-length digit slots and drives the decoder's BCD input plus one-hot digit enables.
- Inserts a dead-time per slot to prevent ghosting and applies 8-level brightness PWM.
- Performs leading-zero blanking.
- Snapshots all digits once per frame so a mid-frame counter update cannot tear the display.

---
 rtl/display_scan_ctrl_pkg.sv | 20 ++
 rtl/display_scan_ctrl_scan_slot_timer.sv | 39 +++
 rtl/display_scan_ctrl.sv | 101 ++++++++++
 tb/tb_display_scan_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared types for the four-digit multiplexed display scanner.
// Digit indices, scan state and nibble selection used by the top and the slot timer.
package display_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [1:0] digIdx_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scanState_t;

    function automatic logic [3:0] getNibble(input logic [15:0] vec, input digIdx_t sel);
        logic [15:0] shifted;
        shifted = vec >> {sel, 2'b00};
        return shifted[3:0];
    endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_slot_timer.sv
// Slot/digit sequencer: counts cycles within a slot and advances the digit index per slot.
// Outputs are registered counters plus combinational end-of-slot / end-of-frame strobes.
module scan_slot_timer
    import display_scan_ctrl_pkg::*;
#(
    parameter int SLOT_LOG2 = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 clear,
    input  logic                 run,
    output logic [SLOT_LOG2-1:0] slot_cnt,
    output digIdx_t              idx,
    output logic                 slot_end,
    output logic                 frame_end
);

    localparam digIdx_t LAST_DIG = digIdx_t'(NUM_DIGITS - 1);

    assign slot_end  = run && (slot_cnt == '1);
    assign frame_end = slot_end && (idx == LAST_DIG);

    // clear outranks run so an abort never lets the slot finish
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            slot_cnt <= '0;
            idx      <= '0;
        end else if (clear) begin
            slot_cnt <= '0;
            idx      <= '0;
        end else if (run) begin
            slot_cnt <= slot_cnt + 1'b1;
            if (slot_end) begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit 7-segment scan controller: dead-time, 8-level PWM, leading-zero blanking, per-frame snapshot.
// Outputs are combinational from registers only; inputs are sampled once per frame.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int SLOT_LOG2 = 4,
    parameter int DEAD      = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic [15:0] DIGITS,
    input  logic [2:0]  BRIGHT,
    input  logic        LZB,
    output logic [3:0]  BCD,
    output logic [3:0]  DIG_EN,
    output logic        BLANK,
    output logic        FRAME
);

    localparam logic [SLOT_LOG2-1:0] DEAD_CNT = SLOT_LOG2'(DEAD);

    scanState_t           state;
    logic [15:0]          snap;
    logic [2:0]           brightQ;
    logic                 lzbQ;
    logic [SLOT_LOG2-1:0] slotCnt;
    digIdx_t              idx;
    logic                 slotEnd;
    logic                 frameEnd;
    logic                 scanning;
    logic                 timerClear;
    logic                 frameReload;
    logic [3:0]           zb;
    logic                 lit;

    assign scanning    = (state == SCAN);
    assign timerClear  = !scanning || !EN;
    assign frameReload = frameEnd && slotEnd;

    scan_slot_timer #(
        .SLOT_LOG2(SLOT_LOG2)
    ) u_timer (
        .CLK       (CLK),
        .RST       (RST),
        .clear     (timerClear),
        .run       (scanning),
        .slot_cnt  (slotCnt),
        .idx       (idx),
        .slot_end  (slotEnd),
        .frame_end (frameEnd)
    );

    // EN low beats a coincident frame boundary: go idle without reloading
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            snap    <= '0;
            brightQ <= '0;
            lzbQ    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (EN) begin
                        state   <= SCAN;
                        snap    <= DIGITS;
                        brightQ <= BRIGHT;
                        lzbQ    <= LZB;
                    end
                end
                SCAN: begin
                    if (!EN) begin
                        state <= IDLE;
                    end else if (frameReload) begin
                        snap    <= DIGITS;
                        brightQ <= BRIGHT;
                        lzbQ    <= LZB;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // digit k is blank only when it and every more-significant digit are zero
    assign zb[0] = 1'b0;
    assign zb[1] = lzbQ && (snap[15:4] == 12'h000);
    assign zb[2] = lzbQ && (snap[15:8] == 8'h00);
    assign zb[3] = lzbQ && (snap[15:12] == 4'h0);

    assign lit = scanning
              && (slotCnt >= DEAD_CNT)
              && (slotCnt[SLOT_LOG2-1 -: 3] <= brightQ)
              && !zb[idx];

    assign DIG_EN = lit ? (4'b0001 << idx) : 4'b0000;
    assign BLANK  = (DIG_EN == 4'b0000);
    assign BCD    = scanning ? getNibble(snap, idx) : 4'h0;
    assign FRAME  = scanning && (idx == 2'd0) && (slotCnt == '0);

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed frame captures with literal expectations plus a randomized
// run, all outputs compared every cycle against a frame-position model.
module tb_display_scan_ctrl;

    localparam int SLOT_LOG2 = 4;
    localparam int DEAD      = 2;
    localparam int SLOT      = 1 << SLOT_LOG2;
    localparam int FRAME_LEN = 4 * SLOT;

    logic        CLK;
    logic        RST;
    logic        EN;
    logic [15:0] DIGITS;
    logic [2:0]  BRIGHT;
    logic        LZB;
    logic [3:0]  BCD;
    logic [3:0]  DIG_EN;
    logic        BLANK;
    logic        FRAME;

    int nChecks = 0;
    int nFails  = 0;

    display_scan_ctrl #(
        .SLOT_LOG2(SLOT_LOG2),
        .DEAD     (DEAD)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .EN     (EN),
        .DIGITS (DIGITS),
        .BRIGHT (BRIGHT),
        .LZB    (LZB),
        .BCD    (BCD),
        .DIG_EN (DIG_EN),
        .BLANK  (BLANK),
        .FRAME  (FRAME)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: scanning flag, position within the frame, and the frame's sampled settings.
    bit          mScan   = 1'b0;
    int          mPhase  = 0;
    logic [15:0] mSnap   = '0;
    int          mBright = 0;
    bit          mLzb    = 1'b0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            mScan  = 1'b0;
            mPhase = 0;
        end else if (!mScan) begin
            if (EN) begin
                mScan   = 1'b1;
                mPhase  = 0;
                mSnap   = DIGITS;
                mBright = BRIGHT;
                mLzb    = LZB;
            end
        end else if (!EN) begin
            mScan  = 1'b0;
            mPhase = 0;
        end else begin
            mPhase = (mPhase + 1) % FRAME_LEN;
            if (mPhase == 0) begin
                mSnap   = DIGITS;
                mBright = BRIGHT;
                mLzb    = LZB;
            end
        end
    end

    always @(negedge CLK) begin
        int          slot;
        int          cyc;
        logic [15:0] upper;
        bit          blanked;
        bit          on;
        logic [3:0]  expBcd;
        logic [3:0]  expDig;
        slot    = mPhase / SLOT;
        cyc     = mPhase % SLOT;
        upper   = mSnap >> (4 * slot);
        blanked = mLzb && (slot > 0) && (upper == 16'h0);
        on      = mScan && (cyc >= DEAD) && (cyc < (mBright + 1) * (SLOT / 8)) && !blanked;
        expBcd  = mScan ? upper[3:0] : 4'h0;
        expDig  = on ? 4'(1 << slot) : 4'h0;
        check("cmp_dig_en", DIG_EN, expDig);
        check("cmp_bcd", BCD, expBcd);
        check("cmp_blank", BLANK, !on);
        check("cmp_frame", FRAME, mScan && (mPhase == 0));
    end

    logic [3:0] recDig [FRAME_LEN];
    logic [3:0] recBcd [FRAME_LEN];
    logic       recFrm [FRAME_LEN];

    task automatic waitFrame(input bit skipCurrent);
        int n = 0;
        if (skipCurrent) @(negedge CLK);
        while (FRAME !== 1'b1 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check("frame_wait", FRAME, 1'b1);
    endtask

    // Records one frame starting at the current (FRAME) cycle; ends at the next frame start.
    task automatic capture(input bit skipCurrent);
        waitFrame(skipCurrent);
        for (int i = 0; i < FRAME_LEN; i++) begin
            recDig[i] = DIG_EN;
            recBcd[i] = BCD;
            recFrm[i] = FRAME;
            @(negedge CLK);
        end
    endtask

    function automatic int litCount(input int k);
        int c = 0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (recDig[i] == 4'(1 << k)) c++;
        end
        return c;
    endfunction

    function automatic int litTotal();
        int c = 0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (recDig[i] != 4'h0) c++;
        end
        return c;
    endfunction

    task automatic stepCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    initial begin
        RST    = 1'b1;
        EN     = 1'b0;
        DIGITS = 16'h0;
        BRIGHT = 3'd0;
        LZB    = 1'b0;

        @(negedge CLK);
        check("rst_dig_en", DIG_EN, 4'h0);
        check("rst_blank", BLANK, 1'b1);
        check("rst_bcd", BCD, 4'h0);
        check("rst_frame", FRAME, 1'b0);

        // full brightness, no blanking
        DIGITS = 16'h1234;
        BRIGHT = 3'd7;
        RST    = 1'b0;
        EN     = 1'b1;
        capture(1'b0);
        check("t1_frame0", recFrm[0], 1'b1);
        check("t1_frame1", recFrm[1], 1'b0);
        check("t1_dead0", recDig[0], 4'h0);
        check("t1_dead1", recDig[1], 4'h0);
        check("t1_lit2", recDig[2], 4'b0001);
        check("t1_bcd_s0", recBcd[0], 4'h4);
        check("t1_s1", recDig[18], 4'b0010);
        check("t1_bcd_s1", recBcd[17], 4'h3);
        check("t1_s2", recDig[34], 4'b0100);
        check("t1_bcd_s2", recBcd[40], 4'h2);
        check("t1_s3_end", recDig[63], 4'b1000);
        check("t1_bcd_s3", recBcd[63], 4'h1);
        check("t1_lit_d0", litCount(0), 14);

        // dimmest: dead-time swallows the whole on-window
        DIGITS = 16'h0005;
        BRIGHT = 3'd0;
        capture(1'b1);
        check("t2_b0_total", litTotal(), 0);
        check("t2_b0_bcd", recBcd[5], 4'h5);
        BRIGHT = 3'd3;
        capture(1'b0);
        check("t2_not_before", litTotal(), 0);
        capture(1'b0);
        check("t2_b3_cnt", litCount(0), 6);
        check("t2_b3_c1", recDig[1], 4'h0);
        check("t2_b3_c2", recDig[2], 4'b0001);
        check("t2_b3_c7", recDig[7], 4'b0001);
        check("t2_b3_c8", recDig[8], 4'h0);

        // leading-zero blanking
        LZB    = 1'b1;
        BRIGHT = 3'd7;
        DIGITS = 16'h0070;
        capture(1'b1);
        check("t3_d3", litCount(3), 0);
        check("t3_d2", litCount(2), 0);
        check("t3_d1", litCount(1), 14);
        check("t3_d0", litCount(0), 14);
        check("t3_bcd1", recBcd[20], 4'h7);
        check("t3_bcd0", recBcd[5], 4'h0);
        DIGITS = 16'h0000;
        capture(1'b1);
        check("t3_zero_total", litTotal(), 14);
        check("t3_zero_d0", litCount(0), 14);
        DIGITS = 16'h0A00;
        capture(1'b1);
        check("t3_a_d3", litCount(3), 0);
        check("t3_a_d2", litCount(2), 14);
        check("t3_a_bcd", recBcd[37], 4'hA);

        // snapshot holds through a mid-frame input change
        LZB    = 1'b0;
        DIGITS = 16'h1111;
        waitFrame(1'b1);
        stepCycles(32);
        DIGITS = 16'h2222;
        stepCycles(5);
        check("t4_slot2", BCD, 4'h1);
        stepCycles(16);
        check("t4_slot3", BCD, 4'h1);
        waitFrame(1'b1);
        stepCycles(5);
        check("t4_next", BCD, 4'h2);
        check("t4_next_en", DIG_EN, 4'b0001);

        // abort mid-slot, then restart
        DIGITS = 16'h1234;
        waitFrame(1'b1);
        stepCycles(SLOT + 7);
        check("t5_pre_bcd", BCD, 4'h3);
        check("t5_pre_en", DIG_EN, 4'b0010);
        EN = 1'b0;
        @(negedge CLK);
        check("t5_off_en", DIG_EN, 4'h0);
        check("t5_off_blank", BLANK, 1'b1);
        check("t5_off_bcd", BCD, 4'h0);
        DIGITS = 16'h9876;
        stepCycles(3);
        check("t5_idle_frame", FRAME, 1'b0);
        EN = 1'b1;
        @(negedge CLK);
        check("t5_re_frame", FRAME, 1'b1);
        check("t5_re_bcd", BCD, 4'h6);

        // asynchronous reset between edges, EN held high
        stepCycles(SLOT + 4);
        check("t6_pre_en", DIG_EN, 4'b0010);
        #2 RST = 1'b1;
        #1;
        check("t6_async_en", DIG_EN, 4'h0);
        check("t6_async_blank", BLANK, 1'b1);
        check("t6_async_bcd", BCD, 4'h0);
        check("t6_async_frame", FRAME, 1'b0);
        @(negedge CLK);
        #2 RST = 1'b0;
        @(negedge CLK);
        check("t6_restart_frame", FRAME, 1'b1);
        check("t6_restart_bcd", BCD, 4'h6);

        // EN falls exactly on the frame boundary
        stepCycles(FRAME_LEN - 1);
        DIGITS = 16'h4321;
        EN     = 1'b0;
        @(negedge CLK);
        check("t7_boundary_idle", FRAME, 1'b0);
        EN = 1'b1;
        @(negedge CLK);
        check("t7_re_bcd", BCD, 4'h1);

        // randomized traffic, checked by the per-cycle model compare
        for (int i = 0; i < 4000; i++) begin
            int r;
            @(negedge CLK);
            r = $urandom_range(0, 199);
            if (r < 2) EN = 1'b0;
            else if (r < 10) EN = 1'b1;
            if (r % 5 == 0) begin
                DIGITS = 16'($urandom);
                if ($urandom_range(0, 1) == 1) DIGITS[15:8] = 8'h00;
                if ($urandom_range(0, 2) == 0) DIGITS[7:4] = 4'h0;
            end
            if (r % 7 == 0) BRIGHT = 3'($urandom_range(0, 7));
            if (r % 11 == 0) LZB = 1'($urandom_range(0, 1));
            if (r == 100) begin
                #2 RST = 1'b1;
                #1 RST = 1'b0;
            end
        end

        @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
